datapath_v2: RTL and testbench
==============================

Name: datapath_v2

Overview:
- Parametrised successor to the 4-bit accumulator/carry/register-file datapath of the CPU core.
- Generalised in word width and register count; adds the test-pin branch condition, increment-and-skip support, and a register-pair load sequencer.
- The sequencer fills an even/odd register pair from two successive data words (FIM/FIN style) and reports busy/done to the control unit.
- Sits between instruction decode (control strobes) and the data bus.

Parameters:
- WIDTH, 4, datapath word width in bits (>= 2).
- NUM_REGS, 16, register-file depth (power of two, >= 2).
- RA_W (localparam), clog2(NUM_REGS), register address width.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- halt  in  1  freezes all state while high
- data  in  WIDTH  data-bus word
- test  in  1  external test pin
- imm  in  WIDTH  instruction immediate
- reg_sel  in  RA_W  register-file address
- cond  in  4  branch condition field
- clear_carry  in  1  carry <= 0
- write_carry  in  1  carry <= ALU carry-out
- clear_accumulator  in  1  acc <= 0
- write_accumulator  in  1  acc <= selected source
- acc_input_sel  in  3  0 REG, 1 DATA, 2 ALU, 3 IMM, 4 CARRY
- write_register  in  1  reg[reg_sel] <= selected source
- reg_input_sel  in  2  0 ACC, 1 ALU, 2 DATA, 3 INC (regval+1)
- alu_op  in  3  0 ADD, 1 SUB, 2 ROL, 3 ROR, 4 CMA, 5 DAA
- alu_in1_sel  in  2  0 REG, 1 DATA, 2 IMM, 3 ZERO
- alu_cin_sel  in  2  0 zero, 1 one, 2 carry, 3 ~carry
- pair_load_start  in  1  start two-word pair load
- pair_sel  in  RA_W-1  pair index p (registers 2p, 2p+1)
- regval  out  WIDTH  reg[reg_sel], combinational
- pair_val  out  2*WIDTH  {reg[2*pair_sel], reg[2*pair_sel+1]}
- acc  out  WIDTH  accumulator
- carry_out  out  1  carry flag
- take_branch  out  1  branch decision
- inc_is_zero  out  1  (regval+1) mod 2^WIDTH == 0
- pair_busy  out  1  sequencer not idle
- pair_done  out  1  one-cycle pulse, pair load finished

Behaviour:
- Reset: acc=0, carry=1, all registers=0, state=IDLE, pair_busy=0, pair_done=0.
- Halt: while halt=1, nothing changes (including the FSM); pair_done is held low.
- ALU (combinational, WIDTH+1-bit result; operand a=acc, b=in1):
  - ADD: a+b+cin.
  - SUB: a+~b+cin (carry=1 means no borrow).
  - ROL: {a,carry}; ROR: {a[0],carry,a[W-1:1]} (rotate through carry).
  - CMA: {carry,~a}.
  - DAA: if a>9 or carry, add 6 and set carry-out to 1, else pass; defined for WIDTH==4 only, otherwise pass-through with carry unchanged.
- Flag priority: clear beats write for both carry and acc; carry and acc are written independently in the same cycle.
- Invalid selects (acc_input_sel 5..7, alu_op 6..7): the target register holds its value.
- Branch: t = (cond[0]&test) | (cond[1]&carry) | (cond[2]&(acc==0)); take_branch = cond[3] ? ~t : t. Combinational on current state.
- INC: reg_input_sel=3 writes regval+1 (wraps). inc_is_zero is computed from pre-write regval so ISZ can branch in the same cycle.
- Pair FSM: IDLE -> HI -> LO -> IDLE.
  - IDLE & pair_load_start: latch pair_sel, go to HI.
  - HI: reg[2p] <= data, go to LO.
  - LO: reg[2p+1] <= data, pulse pair_done, go to IDLE.
  - pair_busy = (state != IDLE).
  - pair_load_start while busy is ignored.
  - write_register while busy is ignored (sequencer owns the write port); acc/carry writes are still allowed.
  - pair_sel changes after the start cycle have no effect.
- Reset mid-pair-load: returns to IDLE and clears registers, with no pair_done pulse.
- Write collision: a normal register write and a sequencer write in the same cycle cannot happen (the sequencer has priority).

Decomposition:
- Shared package/header datapath_v2.vh holds:
  - ACC_IN_*, REG_IN_*, ALU_OP_*, ALU_IN1_*, CIN_* encodings.
  - Pair FSM state encodings.
- One sub-module, alu_v2 (WIDTH parameter), for the op/operand/carry-in mux and DAA.
- Register file, flags and pair FSM stay in datapath_v2.

Test Plan:
- Reset, then read all registers -> all 0, acc=0, carry_out=1, pair_busy=0.
- WIDTH=4: acc=9, carry=0, reg3=5, ADD with cin=0 and write acc+carry -> acc=E, carry=0; then DAA -> acc=4, carry=1.
- pair_load_start with pair_sel=2, then data=A then data=3 -> reg4=A, reg5=3, pair_val=A3, pair_done high for exactly 1 cycle in the LO cycle.
- Assert halt during HI for 3 cycles -> registers and FSM frozen, and the load completes correctly after release; reset during LO -> reg5 unchanged at 0, no pair_done.
- reg7=F, INC write to reg7 -> inc_is_zero=1 in that cycle, reg7=0 afterwards; cond=4'b1100 with acc=0 -> take_branch=0; cond=4'b0001 with test=1 -> take_branch=1.
- write_register while pair_busy targeting reg 4 -> ignored, and the pair data wins; simultaneous clear_carry and write_carry -> carry=0.

Source files
------------

// File: rtl/datapath_v2_pkg.sv
// datapath_v2_pkg: shared select encodings and pair-load FSM states for datapath_v2
package datapath_v2_pkg;
  localparam logic [2:0] ACC_IN_REG = 3'd0, ACC_IN_DATA = 3'd1, ACC_IN_ALU = 3'd2, ACC_IN_IMM = 3'd3, ACC_IN_CARRY = 3'd4;
  localparam logic [1:0] REG_IN_ACC = 2'd0, REG_IN_ALU = 2'd1, REG_IN_DATA = 2'd2, REG_IN_INC = 2'd3;
  localparam logic [2:0] ALU_OP_ADD = 3'd0, ALU_OP_SUB = 3'd1, ALU_OP_ROL = 3'd2, ALU_OP_ROR = 3'd3, ALU_OP_CMA = 3'd4, ALU_OP_DAA = 3'd5;
  localparam logic [1:0] ALU_IN1_REG = 2'd0, ALU_IN1_DATA = 2'd1, ALU_IN1_IMM = 2'd2, ALU_IN1_ZERO = 2'd3;
  localparam logic [1:0] CIN_ZERO = 2'd0, CIN_ONE = 2'd1, CIN_CARRY = 2'd2, CIN_NCARRY = 2'd3;
  typedef enum logic [1:0] {PAIR_IDLE, PAIR_HI, PAIR_LO} pair_state_t;
endpackage

// File: rtl/alu_v2.sv
// alu_v2: operand/carry-in mux and ADD/SUB/ROL/ROR/CMA/DAA on acc (a) vs selected in1; ports a,regval,data,imm,selects,carry in; result,carry_out,valid out
module alu_v2
  import datapath_v2_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] regval,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] imm,
  input  logic [1:0]       in1_sel,
  input  logic [1:0]       cin_sel,
  input  logic [2:0]       op,
  input  logic             carry,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             valid
);
  logic [WIDTH-1:0] b;
  logic             cin;
  logic [WIDTH:0]   sum, dif, daa;
  assign b = in1_sel == ALU_IN1_REG ? regval : in1_sel == ALU_IN1_DATA ? data : in1_sel == ALU_IN1_IMM ? imm : '0;
  assign cin = cin_sel == CIN_ZERO ? 1'b0 : cin_sel == CIN_ONE ? 1'b1 : cin_sel == CIN_CARRY ? carry : ~carry;
  assign sum = {1'b0, a} + {1'b0, b} + (WIDTH+1)'(cin);
  assign dif = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(cin);
  assign daa = (WIDTH == 4 && (a > WIDTH'(9) || carry)) ? {1'b1, a + WIDTH'(6)} : {carry, a};
  assign {carry_out, result} = op == ALU_OP_ADD ? sum : op == ALU_OP_SUB ? dif : op == ALU_OP_ROL ? {a, carry} :
                               op == ALU_OP_ROR ? {a[0], carry, a[WIDTH-1:1]} : op == ALU_OP_CMA ? {carry, ~a} : daa;
  assign valid = op <= ALU_OP_DAA;
endmodule

// File: rtl/datapath_v2.sv
// datapath_v2: acc/carry/register-file datapath with branch test, ISZ support and even/odd pair-load sequencer; strobes in, regval/pair_val/acc/carry_out/take_branch/inc_is_zero/pair_busy/pair_done out
module datapath_v2
  import datapath_v2_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NUM_REGS = 16,
  localparam int RA_W = $clog2(NUM_REGS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                halt,
  input  logic [WIDTH-1:0]    data,
  input  logic                test,
  input  logic [WIDTH-1:0]    imm,
  input  logic [RA_W-1:0]     reg_sel,
  input  logic [3:0]          cond,
  input  logic                clear_carry,
  input  logic                write_carry,
  input  logic                clear_accumulator,
  input  logic                write_accumulator,
  input  logic [2:0]          acc_input_sel,
  input  logic                write_register,
  input  logic [1:0]          reg_input_sel,
  input  logic [2:0]          alu_op,
  input  logic [1:0]          alu_in1_sel,
  input  logic [1:0]          alu_cin_sel,
  input  logic                pair_load_start,
  input  logic [RA_W-2:0]     pair_sel,
  output logic [WIDTH-1:0]    regval,
  output logic [2*WIDTH-1:0]  pair_val,
  output logic [WIDTH-1:0]    acc,
  output logic                carry_out,
  output logic                take_branch,
  output logic                inc_is_zero,
  output logic                pair_busy,
  output logic                pair_done
);
  logic [WIDTH-1:0] rf [NUM_REGS];
  logic [WIDTH-1:0] alu_res, acc_nx, reg_nx;
  logic             alu_cout, alu_ok, acc_ok, reg_ok, t;
  logic [RA_W-2:0]  pair;
  pair_state_t      state, state_nx;
  assign regval = rf[reg_sel];
  assign pair_val = {rf[{pair_sel, 1'b0}], rf[{pair_sel, 1'b1}]};
  alu_v2 #(.WIDTH(WIDTH)) alu (
    .a(acc), .regval(regval), .data(data), .imm(imm),
    .in1_sel(alu_in1_sel), .cin_sel(alu_cin_sel), .op(alu_op), .carry(carry_out),
    .result(alu_res), .carry_out(alu_cout), .valid(alu_ok)
  );
  always_comb begin
    acc_nx = acc_input_sel == ACC_IN_REG ? regval : acc_input_sel == ACC_IN_DATA ? data :
             acc_input_sel == ACC_IN_ALU ? alu_res : acc_input_sel == ACC_IN_IMM ? imm : {{(WIDTH-1){1'b0}}, carry_out};
    acc_ok = acc_input_sel <= ACC_IN_CARRY && (acc_input_sel != ACC_IN_ALU || alu_ok);
    reg_nx = reg_input_sel == REG_IN_ACC ? acc : reg_input_sel == REG_IN_ALU ? alu_res :
             reg_input_sel == REG_IN_DATA ? data : regval + WIDTH'(1);
    reg_ok = reg_input_sel != REG_IN_ALU || alu_ok;
    state_nx = state == PAIR_IDLE ? (pair_load_start ? PAIR_HI : PAIR_IDLE) : state == PAIR_HI ? PAIR_LO : PAIR_IDLE;
  end
  assign t = (cond[0] & test) | (cond[1] & carry_out) | (cond[2] & (acc == '0));
  assign take_branch = cond[3] ? ~t : t;
  assign inc_is_zero = &regval;
  assign pair_busy = state != PAIR_IDLE;
  assign pair_done = state == PAIR_LO && !halt && !reset;
  always_ff @(posedge clock)
    if (reset) state <= PAIR_IDLE;
    else if (!halt) state <= state_nx;
  always_ff @(posedge clock)
    if (reset) begin
      acc <= '0;
      carry_out <= 1'b1;
      pair <= '0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else if (!halt) begin
      if (state == PAIR_IDLE && pair_load_start) pair <= pair_sel;
      if (clear_carry) carry_out <= 1'b0;
      else if (write_carry && alu_ok) carry_out <= alu_cout;
      if (clear_accumulator) acc <= '0;
      else if (write_accumulator && acc_ok) acc <= acc_nx;
      if (state != PAIR_IDLE) rf[{pair, state == PAIR_LO}] <= data;
      else if (write_register && reg_ok) rf[reg_sel] <= reg_nx;
    end
endmodule

// File: tb/tb_datapath_v2.sv
// tb_datapath_v2: vector table, hand sequences and random stimulus against a queue-based reference model
module tb_datapath_v2;
  localparam int W = 4, N = 16, RA = 4, M = 1 << W;
  typedef struct {
    logic rst, halt, test, cc, wc, ca, wa, wr, start;
    logic [W-1:0] data, imm;
    logic [RA-1:0] reg_sel;
    logic [3:0] cond;
    logic [2:0] asel, op;
    logic [1:0] rsel, in1, cs;
    logic [RA-2:0] psel;
  } in_t;
  typedef struct { int a, cy, b, op, cs, ea, ec; } vec_t;
  logic clock = 0;
  in_t c;
  logic [W-1:0] regval, acc;
  logic [2*W-1:0] pair_val;
  logic carry_out, take_branch, inc_is_zero, pair_busy, pair_done;
  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;
  int m_rf[N];
  int m_acc, m_c;
  int q[$];
  vec_t tbl[13];
  always #5 clock = ~clock;
  datapath_v2 #(.WIDTH(W), .NUM_REGS(N)) dut (
    .clock(clock), .reset(c.rst), .halt(c.halt), .data(c.data), .test(c.test), .imm(c.imm),
    .reg_sel(c.reg_sel), .cond(c.cond), .clear_carry(c.cc), .write_carry(c.wc),
    .clear_accumulator(c.ca), .write_accumulator(c.wa), .acc_input_sel(c.asel),
    .write_register(c.wr), .reg_input_sel(c.rsel), .alu_op(c.op), .alu_in1_sel(c.in1),
    .alu_cin_sel(c.cs), .pair_load_start(c.start), .pair_sel(c.psel),
    .regval(regval), .pair_val(pair_val), .acc(acc), .carry_out(carry_out),
    .take_branch(take_branch), .inc_is_zero(inc_is_zero), .pair_busy(pair_busy), .pair_done(pair_done)
  );
  function automatic in_t idle();
    in_t x;
    x = '{rst: 0, halt: 0, test: 0, cc: 0, wc: 0, ca: 0, wa: 0, wr: 0, start: 0, data: 0, imm: 0,
          reg_sel: 0, cond: 0, asel: 0, op: 0, rsel: 0, in1: 0, cs: 0, psel: 0};
    return x;
  endfunction
  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic void m_alu(input int op, a, b, ci, cy, output int ok, res, co);
    int s;
    ok = op <= 5;
    res = a;
    co = cy;
    case (op)
      0: begin s = a + b + ci; res = s % M; co = s >= M; end
      1: begin s = a + (M - 1 - b) + ci; res = s % M; co = s >= M; end
      2: begin res = (a * 2 + cy) % M; co = a >= M / 2; end
      3: begin res = a / 2 + cy * (M / 2); co = a % 2; end
      4: begin res = M - 1 - a; co = cy; end
      5: if (W == 4 && (a > 9 || cy != 0)) begin res = (a + 6) % M; co = 1; end
      default: ;
    endcase
  endfunction
  function automatic void m_eval(output int ok, res, co);
    int rv, b, ci;
    rv = m_rf[c.reg_sel];
    b = c.in1 == 0 ? rv : c.in1 == 1 ? int'(c.data) : c.in1 == 2 ? int'(c.imm) : 0;
    ci = c.cs == 0 ? 0 : c.cs == 1 ? 1 : c.cs == 2 ? m_c : 1 - m_c;
    m_alu(int'(c.op), m_acc, b, ci, m_c, ok, res, co);
  endfunction
  task automatic m_step();
    int ok, res, co, rv, oa, oc;
    bit busy0;
    if (c.rst) begin
      foreach (m_rf[i]) m_rf[i] = 0;
      m_acc = 0;
      m_c = 1;
      q.delete();
      return;
    end
    if (c.halt) return;
    m_eval(ok, res, co);
    rv = m_rf[c.reg_sel];
    oa = m_acc;
    oc = m_c;
    busy0 = q.size() != 0;
    if (c.cc) m_c = 0;
    else if (c.wc && ok != 0) m_c = co;
    if (c.ca) m_acc = 0;
    else if (c.wa)
      case (c.asel)
        0: m_acc = rv;
        1: m_acc = c.data;
        2: if (ok != 0) m_acc = res;
        3: m_acc = c.imm;
        4: m_acc = oc;
        default: ;
      endcase
    if (busy0) m_rf[q.pop_front()] = c.data;
    else if (c.wr)
      case (c.rsel)
        0: m_rf[c.reg_sel] = oa;
        1: if (ok != 0) m_rf[c.reg_sel] = res;
        2: m_rf[c.reg_sel] = c.data;
        default: m_rf[c.reg_sel] = (rv + 1) % M;
      endcase
    if (!busy0 && c.start) begin
      q.push_back(2 * c.psel);
      q.push_back(2 * c.psel + 1);
    end
  endtask
  task automatic m_check();
    int rv, t;
    rv = m_rf[c.reg_sel];
    t = (c.cond[0] && c.test) || (c.cond[1] && m_c != 0) || (c.cond[2] && m_acc == 0);
    chk("regval", regval, rv);
    chk("pair_val", pair_val, m_rf[2 * c.psel] * M + m_rf[2 * c.psel + 1]);
    chk("acc", acc, m_acc);
    chk("carry", carry_out, m_c);
    chk("take_branch", take_branch, c.cond[3] ? 1 - t : t);
    chk("inc_is_zero", inc_is_zero, (rv + 1) % M == 0);
    chk("pair_busy", pair_busy, q.size() != 0);
    chk("pair_done", pair_done, q.size() == 1 && !c.halt && !c.rst);
  endtask
  task automatic cyc();
    @(negedge clock);
    if (chk_en) m_check();
    @(posedge clock);
    m_step();
    #1;
  endtask
  task automatic set_acc(int v);
    c = idle(); c.wa = 1; c.asel = 3; c.imm = W'(v);
    cyc();
  endtask
  task automatic set_reg(int r, int v);
    c = idle(); c.wr = 1; c.rsel = 2; c.reg_sel = RA'(r); c.data = W'(v);
    cyc();
  endtask
  initial begin
    tbl = '{'{9, 0, 5, 0, 0, 'hE, 0}, '{9, 0, 7, 0, 1, 1, 1}, '{5, 0, 3, 1, 1, 2, 1}, '{3, 0, 5, 1, 1, 'hE, 0},
            '{9, 1, 0, 2, 0, 3, 1}, '{6, 1, 0, 3, 0, 'hB, 0}, '{5, 0, 0, 4, 0, 'hA, 0}, '{'hE, 0, 0, 5, 0, 4, 1},
            '{5, 0, 0, 5, 0, 5, 0}, '{3, 1, 0, 5, 0, 9, 1}, '{8, 1, 8, 1, 2, 0, 1}, '{2, 0, 3, 0, 3, 6, 0},
            '{7, 1, 0, 6, 0, 7, 1}};
    c = idle(); c.rst = 1;
    cyc();
    chk_en = 1;
    c = idle(); #1;
    chk("rst_acc", acc, 0); chk("rst_carry", carry_out, 1); chk("rst_busy", pair_busy, 0); chk("rst_done", pair_done, 0);
    for (int r = 0; r < N; r++) begin
      c.reg_sel = RA'(r); #1;
      chk("rst_reg", regval, 0);
      cyc();
    end
    foreach (tbl[i]) begin
      c = idle(); c.wa = 1; c.asel = 3; c.imm = W'(tbl[i].a);
      if (tbl[i].cy != 0) begin c.wc = 1; c.op = 1; c.in1 = 3; c.cs = 1; end
      else c.cc = 1;
      cyc();
      c = idle(); c.wa = 1; c.asel = 2; c.wc = 1; c.op = 3'(tbl[i].op); c.in1 = 2; c.imm = W'(tbl[i].b); c.cs = 2'(tbl[i].cs);
      cyc();
      chk("vec_acc", acc, tbl[i].ea);
      chk("vec_carry", carry_out, tbl[i].ec);
    end
    set_acc(9);
    c = idle(); c.cc = 1; cyc();
    set_reg(3, 5);
    c = idle(); c.wa = 1; c.asel = 2; c.wc = 1; c.op = 0; c.in1 = 0; c.cs = 0; c.reg_sel = 3; cyc();
    chk("add_acc", acc, 'hE); chk("add_carry", carry_out, 0);
    c.op = 5; cyc();
    chk("daa_acc", acc, 4); chk("daa_carry", carry_out, 1);
    c = idle(); c.start = 1; c.psel = 2; cyc();
    chk("pl_busy", pair_busy, 1);
    c = idle(); c.data = 'hA; c.psel = 1; #1;
    chk("pl_hi_done", pair_done, 0);
    cyc();
    c = idle(); c.data = 3; #1;
    chk("pl_lo_done", pair_done, 1);
    cyc();
    c = idle(); c.psel = 2; c.reg_sel = 4; #1;
    chk("pl_after_done", pair_done, 0); chk("pl_after_busy", pair_busy, 0);
    chk("pl_reg4", regval, 'hA); chk("pl_pair", pair_val, 'hA3);
    cyc();
    c = idle(); c.start = 1; c.psel = 3; cyc();
    for (int i = 0; i < 3; i++) begin
      c = idle(); c.halt = 1; c.data = 'hF; c.psel = 3; #1;
      chk("halt_busy", pair_busy, 1); chk("halt_done", pair_done, 0); chk("halt_pair", pair_val, 0);
      cyc();
    end
    c = idle(); c.data = 5; c.psel = 3; cyc();
    c.data = 9; #1;
    chk("halt_lo_done", pair_done, 1);
    cyc();
    chk("halt_pair_final", pair_val, 'h59);
    c = idle(); c.start = 1; c.psel = 2; cyc();
    c = idle(); c.data = 7; cyc();
    c = idle(); c.rst = 1; c.data = 8; #1;
    chk("rst_lo_done", pair_done, 0);
    cyc();
    c = idle(); c.reg_sel = 5; #1;
    chk("rst_lo_reg5", regval, 0); chk("rst_lo_busy", pair_busy, 0);
    cyc();
    set_reg(7, 'hF);
    c = idle(); c.wr = 1; c.rsel = 3; c.reg_sel = 7; #1;
    chk("isz_zero", inc_is_zero, 1);
    cyc();
    c = idle(); c.reg_sel = 7; c.cond = 4'b1100; #1;
    chk("inc_wrap", regval, 0); chk("br_1100", take_branch, 0);
    c.cond = 4'b0001; c.test = 1; #1;
    chk("br_0001", take_branch, 1);
    cyc();
    c = idle(); c.start = 1; c.psel = 2; cyc();
    c = idle(); c.data = 'hC; c.wr = 1; c.rsel = 0; c.reg_sel = 4; c.cc = 1; c.wc = 1; c.op = 1; c.in1 = 3; c.cs = 1; cyc();
    chk("cc_wins", carry_out, 0);
    c = idle(); c.data = 'hD; c.wr = 1; c.rsel = 2; c.reg_sel = 5; cyc();
    c = idle(); c.psel = 2; #1;
    chk("seq_owns_wr", pair_val, 'hCD);
    cyc();
    for (int i = 0; i < 3000; i++) begin
      c.rst = $urandom_range(0, 99) == 0;
      c.halt = $urandom_range(0, 7) == 0;
      c.start = $urandom_range(0, 3) == 0;
      c.test = 1'($urandom); c.cc = $urandom_range(0, 5) == 0; c.wc = 1'($urandom);
      c.ca = $urandom_range(0, 5) == 0; c.wa = 1'($urandom); c.wr = 1'($urandom);
      c.data = W'($urandom); c.imm = W'($urandom); c.reg_sel = RA'($urandom); c.cond = 4'($urandom);
      c.asel = 3'($urandom); c.op = 3'($urandom); c.rsel = 2'($urandom); c.in1 = 2'($urandom);
      c.cs = 2'($urandom); c.psel = (RA-1)'($urandom);
      cyc();
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
